iob_native_master: RTL and testbench
====================================

# iob_native_master

Bus initiator for the IOb native interface: accepts one command at a time on a valid/ready command port and executes it as an IOb write, read, or poll-read against a slave peripheral's register file. Examples of such slaves are the GPIO and PWM register blocks. Used by the test/boot sequencer and by debug bridges to drive peripherals without a CPU. Every bus request has its own timeout, so a hung slave cannot lock the initiator.

## Interface
- ADDR_W, 16: IOb address width.
- DATA_W, 32: IOb data width; wstrb width is DATA_W/8.
- TIMEOUT, 256: maximum cycles m_valid is held per request, range 2..65535.
- POLL_MAX, 16: maximum reads per poll command, range ≥1.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_poll  in  1  read repeatedly until match; ignored when cmd_write=1
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data; for polls, the expected value
- cmd_wstrb  in  DATA_W/8  byte enables; all-zero on a write is forced to all-ones
- cmd_mask  in  DATA_W  poll compare mask
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  last read data; 0 for writes
- rsp_status  out  2  00 OK, 01 TIMEOUT, 10 POLL_FAIL
- m_valid  out  1  IOb request
- m_address  out  ADDR_W  IOb address
- m_wdata  out  DATA_W  IOb write data; 0 for reads
- m_wstrb  out  DATA_W/8  IOb byte enables; 0 for reads
- m_rdata  in  DATA_W  IOb read data, valid when m_ready=1
- m_ready  in  1  IOb completion, one cycle per request

## Operation
- The FSM has four states: IDLE, REQ, GAP and RSP.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid, latch all cmd_* fields, clear the timeout and retry counters, and go to REQ.
- **REQ**
  - m_valid=1; m_address, m_wdata and m_wstrb are stable from the latched command.
  - When m_ready=1:
    - Capture m_rdata.
    - A write or a plain read goes to RSP with status OK.
    - A poll whose ((m_rdata ^ wdata) & mask) equals 0 goes to RSP with status OK.
    - A poll with no match increments the retry counter. If the counter now equals POLL_MAX, go to RSP with status POLL_FAIL; otherwise go to GAP.
  - When m_ready=0 and the timeout counter equals TIMEOUT-1, go to RSP with status TIMEOUT and rsp_rdata=0. The slave transaction is abandoned.
  - m_ready takes precedence over timeout in the same cycle.
- **GAP**
  - m_valid=0 for exactly one cycle.
  - The timeout counter is cleared, then the FSM returns to REQ. Every poll read gets a fresh timeout.
- **RSP**
  - rsp_valid=1, with rsp_rdata and rsp_status held stable until rsp_ready=1, then go to IDLE.
  - cmd_ready=0 in every state except IDLE.
- An m_ready seen outside REQ is ignored.
- Asserting rst_n low at any point forces IDLE immediately. All registered outputs clear; a pending response is lost.

## Timing
- Reset values:
  - m_valid, m_address, m_wdata, m_wstrb: 0.
  - rsp_valid, rsp_rdata, rsp_status: 0.
  - cmd_ready: 1.
- All m_* and rsp_* outputs are registered. cmd_ready is decoded from the state register.
- Command accepted at edge N: m_valid=1 from cycle N+1.
- m_ready high in cycle M: m_valid=0 and rsp_valid=1 in cycle M+1.
- Zero-wait slave: accept to rsp_valid is 2 cycles.
- Timeout: m_valid is high for exactly TIMEOUT cycles, then rsp_valid rises in the next cycle.
- Poll: each retry costs ready latency plus 1 GAP cycle.
- Back-to-back commands: at least 1 idle cycle between rsp handshake and next cmd acceptance.

## Structure
- Package iob_native_master_pkg holds:
  - the state enum (IDLE, REQ, GAP, RSP);
  - status constants ST_OK, ST_TIMEOUT and ST_POLL_FAIL.
- One sub-module, iob_nm_timer: a clear/enable counter of $clog2(TIMEOUT) bits with an expired flag at TIMEOUT-1. It is reused for the retry count with POLL_MAX.

## Test plan
- Write: addr 0x0004, wdata 0xA5A5_0001, wstrb 0xF, slave ready after 3 cycles. Expect m_valid high for 3 cycles, m_wstrb=0xF, then rsp_status=00 and rsp_rdata=0.
- Write with wstrb=0: expect m_wstrb=0xF on the bus.
- Read: zero-wait slave returns 0xDEAD_BEEF. Expect rsp_valid 2 cycles after accept, rsp_rdata=0xDEAD_BEEF, status 00.
- Poll: mask 0x1, expected 0x1; slave returns 0,0,0,1. Expect 4 requests, each separated by one m_valid=0 cycle, then status 00 with rsp_rdata=1.
- Poll with POLL_MAX=4 and a slave always returning 0. Expect exactly 4 requests, status 10, rsp_rdata=0.
- Timeout: TIMEOUT=8 with a slave never ready. Expect m_valid high exactly 8 cycles, then status 01.
- Ready on the 8th cycle: expect status 00.
- rst_n low mid-REQ: expect m_valid=0 asynchronously, cmd_ready=1 after release, and a subsequent read completing normally.

Source files
------------

// File: rtl/iob_native_master_pkg.sv
// rtl/iob_native_master_pkg.sv - shared types and constants for the IOb native initiator
package iob_native_master_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2,
      RSP  = 2'd3
   } nm_state_t;

   localparam logic [1:0] ST_OK        = 2'b00;
   localparam logic [1:0] ST_TIMEOUT   = 2'b01;
   localparam logic [1:0] ST_POLL_FAIL = 2'b10;

   // A limit of 1 still needs one bit so the counter has a legal width.
   function automatic int timer_width(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/iob_nm_timer.sv
// rtl/iob_nm_timer.sv - clear/enable counter flagging its last count (LIMIT-1)
module iob_nm_timer
   import iob_native_master_pkg::*;
#(
   parameter int LIMIT = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = timer_width(LIMIT);
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/iob_native_master.sv
// rtl/iob_native_master.sv - single-command IOb initiator with write, read and poll-read
module iob_native_master
   import iob_native_master_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 32,
   parameter int TIMEOUT  = 256,
   parameter int POLL_MAX = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic                cmd_poll,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_wstrb,
   input  logic [DATA_W-1:0]   cmd_mask,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_status,
   output logic                m_valid,
   output logic [ADDR_W-1:0]   m_address,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic                m_ready
);

   localparam int STRB_W = DATA_W / 8;

   nm_state_t state, state_nxt;

   logic              lat_write;
   logic              lat_poll;
   logic [DATA_W-1:0] lat_exp;
   logic [DATA_W-1:0] lat_mask;

   logic              to_clr, to_en, to_exp;
   logic              rt_clr, rt_en, rt_exp;

   logic              rsp_load;
   logic [1:0]        status_nxt;
   logic [DATA_W-1:0] rdata_nxt;
   logic              accept;
   logic              poll_hit;

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_ready && cmd_valid;
   assign poll_hit  = ((m_rdata ^ lat_exp) & lat_mask) == '0;

   iob_nm_timer #(.LIMIT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (to_clr),
      .en      (to_en),
      .expired (to_exp)
   );

   // Retry counter: flags the last allowed poll read rather than counting past it.
   iob_nm_timer #(.LIMIT(POLL_MAX)) u_retry (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (rt_clr),
      .en      (rt_en),
      .expired (rt_exp)
   );

   always_comb begin
      state_nxt  = state;
      to_clr     = 1'b0;
      to_en      = 1'b0;
      rt_clr     = 1'b0;
      rt_en      = 1'b0;
      rsp_load   = 1'b0;
      status_nxt = ST_OK;
      rdata_nxt  = '0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               to_clr    = 1'b1;
               rt_clr    = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (m_ready) begin
               if (lat_write || !lat_poll) begin
                  rsp_load  = 1'b1;
                  rdata_nxt = lat_write ? '0 : m_rdata;
                  state_nxt = RSP;
               end else if (poll_hit) begin
                  rsp_load  = 1'b1;
                  rdata_nxt = m_rdata;
                  state_nxt = RSP;
               end else begin
                  rt_en = 1'b1;
                  if (rt_exp) begin
                     rsp_load   = 1'b1;
                     status_nxt = ST_POLL_FAIL;
                     rdata_nxt  = m_rdata;
                     state_nxt  = RSP;
                  end else begin
                     state_nxt = GAP;
                  end
               end
            end else if (to_exp) begin
               rsp_load   = 1'b1;
               status_nxt = ST_TIMEOUT;
               state_nxt  = RSP;
            end else begin
               to_en = 1'b1;
            end
         end
         GAP: begin
            to_clr    = 1'b1;
            state_nxt = REQ;
         end
         RSP: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         m_valid    <= 1'b0;
         m_address  <= '0;
         m_wdata    <= '0;
         m_wstrb    <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_status <= ST_OK;
         lat_write  <= 1'b0;
         lat_poll   <= 1'b0;
         lat_exp    <= '0;
         lat_mask   <= '0;
      end else begin
         state   <= state_nxt;
         m_valid <= (state_nxt == REQ);
         if (accept) begin
            lat_write <= cmd_write;
            lat_poll  <= cmd_poll && !cmd_write;
            lat_exp   <= cmd_wdata;
            lat_mask  <= cmd_mask;
            m_address <= cmd_addr;
            // Reads present zero data/strobes; an empty write strobe means a full-word write.
            if (cmd_write) begin
               m_wdata <= cmd_wdata;
               m_wstrb <= (cmd_wstrb == '0) ? {STRB_W{1'b1}} : cmd_wstrb;
            end else begin
               m_wdata <= '0;
               m_wstrb <= '0;
            end
         end
         if (rsp_load) begin
            rsp_valid  <= 1'b1;
            rsp_rdata  <= rdata_nxt;
            rsp_status <= status_nxt;
         end else if (state == RSP && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_iob_native_master.sv
// tb/tb_iob_native_master.sv - directed self-checking bench for iob_native_master
module tb_iob_native_master;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic        cmd_poll;
   logic [15:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic [31:0] cmd_mask;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_status;
   logic        m_valid;
   logic [15:0] m_address;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic [31:0] m_rdata;
   logic        m_ready;

   int n_cmp  = 0;
   int n_fail = 0;

   int          slave_lat;
   int          vrun;
   logic [31:0] rd_q [8];
   int          got_lat, got_reqs, got_vcyc;
   logic [3:0]  got_strb;
   logic [31:0] got_wdata, got_rdata;
   logic [15:0] got_addr;
   logic [1:0]  got_status;

   iob_native_master #(
      .ADDR_W   (16),
      .DATA_W   (32),
      .TIMEOUT  (8),
      .POLL_MAX (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_poll   (cmd_poll),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .cmd_wstrb  (cmd_wstrb),
      .cmd_mask   (cmd_mask),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_status (rsp_status),
      .m_valid    (m_valid),
      .m_address  (m_address),
      .m_wdata    (m_wdata),
      .m_wstrb    (m_wstrb),
      .m_rdata    (m_rdata),
      .m_ready    (m_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Slave model, evaluated once per cycle at the falling edge.
   task automatic slave_step();
      if (m_valid) begin
         vrun++;
         got_vcyc++;
         if (vrun == 1) got_reqs++;
         got_addr  = m_address;
         got_wdata = m_wdata;
         got_strb  = m_wstrb;
         if (slave_lat != 0 && vrun == slave_lat) begin
            m_ready = 1'b1;
            m_rdata = rd_q[(got_reqs - 1) % 8];
         end else begin
            m_ready = 1'b0;
            m_rdata = 32'hBAD0_BAD0;
         end
      end else begin
         vrun    = 0;
         m_ready = 1'b0;
         m_rdata = 32'hBAD0_BAD0;
      end
   endtask

   task automatic issue(input logic wr, input logic pl, input logic [15:0] addr,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input logic [31:0] mk, input int lat);
      slave_lat = lat;
      got_lat   = -1;
      got_reqs  = 0;
      got_vcyc  = 0;
      vrun      = 0;
      @(negedge clk);
      cmd_write = wr;
      cmd_poll  = pl;
      cmd_addr  = addr;
      cmd_wdata = wd;
      cmd_wstrb = ws;
      cmd_mask  = mk;
      cmd_valid = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         slave_step();
         if (rsp_valid) begin
            got_lat = k;
            break;
         end
      end
      got_rdata  = rsp_rdata;
      got_status = rsp_status;
      rsp_ready  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      slave_step();
      check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
      check("cmd_ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_poll  = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_wstrb = '0;
      cmd_mask  = '0;
      rsp_ready = 1'b0;
      m_ready   = 1'b0;
      m_rdata   = 32'hBAD0_BAD0;
      slave_lat = 0;
      vrun      = 0;
      for (int i = 0; i < 8; i++) rd_q[i] = '0;

      repeat (3) @(negedge clk);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_m_valid", {31'd0, m_valid}, 32'd0);
      check("rst_m_address", {16'd0, m_address}, 32'd0);
      check("rst_m_wdata", m_wdata, 32'd0);
      check("rst_m_wstrb", {28'd0, m_wstrb}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_status", {30'd0, rsp_status}, 32'd0);
      rst_n = 1'b1;

      // Write, slave ready after 3 cycles
      issue(1'b1, 1'b0, 16'h0004, 32'hA5A5_0001, 4'hF, 32'h0, 3);
      check("wr_vcycles", got_vcyc, 32'd3);
      check("wr_addr", {16'd0, got_addr}, 32'h0004);
      check("wr_wdata", got_wdata, 32'hA5A5_0001);
      check("wr_wstrb", {28'd0, got_strb}, 32'hF);
      check("wr_latency", got_lat, 32'd4);
      check("wr_status", {30'd0, got_status}, 32'd0);
      check("wr_rdata", got_rdata, 32'd0);

      // Write with empty strobe becomes a full-word write
      issue(1'b1, 1'b0, 16'h0008, 32'h0000_00FF, 4'h0, 32'h0, 1);
      check("wr0_wstrb", {28'd0, got_strb}, 32'hF);
      check("wr0_latency", got_lat, 32'd2);

      // Zero-wait read; write data and strobes must be zero on the bus
      rd_q[0] = 32'hDEAD_BEEF;
      issue(1'b0, 1'b0, 16'h0010, 32'h1234_5678, 4'hF, 32'h0, 1);
      check("rd_latency", got_lat, 32'd2);
      check("rd_rdata", got_rdata, 32'hDEAD_BEEF);
      check("rd_status", {30'd0, got_status}, 32'd0);
      check("rd_wdata", got_wdata, 32'd0);
      check("rd_wstrb", {28'd0, got_strb}, 32'd0);
      check("rd_addr", {16'd0, got_addr}, 32'h0010);

      // Poll on bit 0, matching on the 4th read
      rd_q[0] = 32'h0000_00F0;
      rd_q[1] = 32'h0000_00F0;
      rd_q[2] = 32'h0000_00F0;
      rd_q[3] = 32'h0000_00F1;
      issue(1'b0, 1'b1, 16'h0020, 32'h0000_0001, 4'h0, 32'h0000_0001, 1);
      check("poll_reqs", got_reqs, 32'd4);
      check("poll_vcycles", got_vcyc, 32'd4);
      check("poll_latency", got_lat, 32'd8);
      check("poll_status", {30'd0, got_status}, 32'd0);
      check("poll_rdata", got_rdata, 32'h0000_00F1);

      // Poll that never matches exhausts POLL_MAX=4 reads
      for (int i = 0; i < 8; i++) rd_q[i] = '0;
      issue(1'b0, 1'b1, 16'h0024, 32'h0000_0005, 4'h0, 32'hFFFF_FFFF, 1);
      check("pfail_reqs", got_reqs, 32'd4);
      check("pfail_latency", got_lat, 32'd8);
      check("pfail_status", {30'd0, got_status}, 32'd2);
      check("pfail_rdata", got_rdata, 32'd0);

      // Slave never ready: TIMEOUT=8 cycles of m_valid
      issue(1'b0, 1'b0, 16'h0030, 32'h0, 4'h0, 32'h0, 0);
      check("to_reqs", got_reqs, 32'd1);
      check("to_vcycles", got_vcyc, 32'd8);
      check("to_latency", got_lat, 32'd9);
      check("to_status", {30'd0, got_status}, 32'd1);
      check("to_rdata", got_rdata, 32'd0);

      // Ready on the last allowed cycle wins over the timeout
      rd_q[0] = 32'h00C0_FFEE;
      issue(1'b0, 1'b0, 16'h0034, 32'h0, 4'h0, 32'h0, 8);
      check("to8_vcycles", got_vcyc, 32'd8);
      check("to8_status", {30'd0, got_status}, 32'd0);
      check("to8_rdata", got_rdata, 32'h00C0_FFEE);

      // Poll flag on a write is ignored: one request only
      rd_q[0] = 32'hFFFF_FFFF;
      issue(1'b1, 1'b1, 16'h0040, 32'h0000_0000, 4'h3, 32'hFFFF_FFFF, 2);
      check("wrpoll_reqs", got_reqs, 32'd1);
      check("wrpoll_status", {30'd0, got_status}, 32'd0);
      check("wrpoll_wstrb", {28'd0, got_strb}, 32'h3);

      // Asynchronous reset in the middle of a request
      slave_lat = 0;
      vrun      = 0;
      @(negedge clk);
      cmd_write = 1'b0;
      cmd_poll  = 1'b0;
      cmd_addr  = 16'h0050;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      slave_step();
      @(negedge clk);
      slave_step();
      check("mid_m_valid", {31'd0, m_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_m_valid", {31'd0, m_valid}, 32'd0);
      check("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("arst_m_address", {16'd0, m_address}, 32'd0);
      @(negedge clk);
      slave_step();
      rst_n = 1'b1;
      @(negedge clk);
      slave_step();
      check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);

      rd_q[0] = 32'h1357_9BDF;
      issue(1'b0, 1'b0, 16'h0054, 32'h0, 4'h0, 32'h0, 1);
      check("post_rst_latency", got_lat, 32'd2);
      check("post_rst_rdata", got_rdata, 32'h1357_9BDF);
      check("post_rst_status", {30'd0, got_status}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
